ram64x8_arbiter: RTL and testbench
==================================

# ram64x8_arbiter

Two-port arbiter and sequencer for the single-port 64x8 RAM (`singleport_RAM64x8_design`). It lets two independent requesters share the RAM through a req/ack handshake, serialises their accesses, and drives the RAM's enable, read, address and data inputs one transaction at a time. It sits between the requesters and the RAM instance; the RAM's `reset` is wired to the same system reset at top level.

## Interface

Parameters:
- `AW`, 6: address width, for 64 words.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  per-port transaction request.
- `we0`, `we1`  in  1  per-port write select; 1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  per-port word address.
- `wdata0`, `wdata1`  in  DW  per-port write data.
- `gnt0`, `gnt1`  out  1  high while that port's transaction is in flight.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  registered read data; valid at ack, held until that port's next read ack.
- `ram_enable`  out  1  drives RAM `enable`.
- `ram_read`  out  1  drives RAM `read`; 1 = read, 0 = write.
- `ram_address`  out  AW  drives RAM `address`.
- `ram_data_in`  out  DW  drives RAM `data_in`.
- `ram_data_out`  in  DW  from RAM `data_out`; valid the cycle after a read is issued.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Samples `req0` and `req1`.
  - If any request is present, the winner's `we`, `addr` and `wdata` are latched into command registers, the winner's `gnt` is set, and the FSM moves to ISSUE.
  - With no request, the FSM stays in IDLE.
- **ISSUE**
  - `ram_enable` = 1 for exactly this cycle.
  - `ram_read` = ~latched `we`; `ram_address` and `ram_data_in` come from the command registers.
  - Next state: WAIT.
- **WAIT**
  - `ram_enable` = 0.
  - On a read, `ram_data_out` is captured into the winner's `rdata` at the end of this cycle.
  - Next state: DONE.
- **DONE**
  - Winner's `ack` = 1; `gnt` is still high.
  - Requests are ignored in this state.
  - Next state: IDLE, with `gnt` cleared.
- `rdata` is unchanged on writes. The loser's outputs are untouched.
- **Requester rule**
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until the ack cycle.
  - Deassert `req` by the edge at which `ack` is high, unless a back-to-back transaction is wanted.
  - A `req` still high in the following IDLE cycle is treated as a new transaction.
- **Arbitration:** if only one port requests, that port wins. If both request, see Configuration.
- **RAM outputs**
  - `ram_address` and `ram_data_in` hold the last latched command between transactions.
  - `ram_read` = 0 whenever `ram_enable` = 0.

## Timing

- Request sampled in IDLE at cycle 0:
  - `ram_enable` is high in cycle 1.
  - RAM data is valid in cycle 2.
  - `ack` and `rdata` are valid in cycle 3.
- Latency is 3 cycles from a sampled request to `ack`. Throughput is 1 transaction per 4 cycles.
- **Reset values:** FSM = IDLE; all `gnt`, `ack` = 0; `rdata0`, `rdata1` = 0; `ram_enable`, `ram_read` = 0; `ram_address`, `ram_data_in` = 0; priority pointer favours port 0.
- **Reset mid-operation:** the next state is IDLE and no `ack` is produced for the aborted transaction.
  - A write whose ISSUE cycle has already completed is committed in the RAM.
  - A reset coincident with ISSUE aborts the write, because the RAM is also reset.
- **Address 63** is an ordinary address; there is no wrap or overflow logic. Address arithmetic is never performed.

## Configuration

- Macro `RAM_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - A 1-bit last-grant pointer is updated in DONE.
  - On simultaneous requests, the port not granted last wins.
  - After reset, port 0 wins the first tie.
- **Undefined:** fixed priority, port 0 always wins ties.
  - Port 1 can starve while `req0` is held continuously.
  - No pointer register is built.

## Test plan

- **Single write:** reset, then `req0` with `we0`=1, `addr0`=5, `wdata0`=0xA5 -> exactly one cycle of `ram_enable`=1, `ram_read`=0, `ram_address`=5, `ram_data_in`=0xA5; `ack0` high 3 cycles after the request is sampled; `rdata0` stays 0.
- **Read back:** `req0` read of `addr0`=5 -> `ram_read`=1 in ISSUE; `rdata0`=0xA5 with `ack0`; `gnt1` and `ack1` stay 0 throughout.
- **Tie, round-robin:** with the macro defined, from reset, `req0` writes 0x10 to address 1 and `req1` writes 0x20 to address 2 in the same cycle -> port 0 acks first and port 1 acks 4 cycles later. Reads of addresses 1 and 2 then return 0x10 and 0x20.
- **Tie, fixed priority:** with the macro undefined, `req0` and `req1` are held high continuously -> only `ack0` pulses, every 4 cycles. With the macro defined, `ack0` and `ack1` alternate.
- **Top address:** port 1 writes 0x3F to address 63, then reads address 63 -> `rdata1`=0x3F; address 0 is unaffected.
- **Reset mid-read:** `reset`=1 during the WAIT cycle of a port 0 read -> next cycle is IDLE with `gnt0`=0, no `ack0` pulse, `rdata0`=0, `ram_enable`=0.

Source files
------------

// File: rtl/ram64x8_arbiter.sv
// Two-requester req/ack front end that serialises accesses to the single-port 64x8 RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module ram64x8_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_enable,
    output logic          ram_read,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q;
    logic          win_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic [1:0]    gnt_q;
    logic [1:0]    ack_q;
    logic          en_q;
    logic          rd_q;

    logic          win_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    always_comb begin
        // On a tie the port that was not served last goes first.
        if (req0 && req1) begin
            win_d = ~last_q;
        end else begin
            win_d = req1;
        end
    end
`else
    always_comb begin
        win_d = req1 && !req0;
    end
`endif

    always_comb begin
        we_d    = win_d ? we1    : we0;
        addr_d  = win_d ? addr1  : addr0;
        wdata_d = win_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            en_q     <= 1'b0;
            rd_q     <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q   <= win_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        gnt_q   <= {win_d, ~win_d};
                        en_q    <= 1'b1;
                        rd_q    <= ~we_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    en_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!we_q) begin
                        if (win_q) begin
                            rdata1_q <= ram_data_out;
                        end else begin
                            rdata0_q <= ram_data_out;
                        end
                    end
                    ack_q   <= {win_q, ~win_q};
                    state_q <= DONE;
                end
                DONE: begin
                    gnt_q   <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_q  <= win_q;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign ack0        = ack_q[0];
    assign ack1        = ack_q[1];
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign ram_enable  = en_q;
    assign ram_read    = rd_q;
    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;

endmodule

// File: tb/tb_ram64x8_arbiter.sv
// Self-checking bench for ram64x8_arbiter with a behavioural 64x8 RAM attached.
// Honours RAM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_ram64x8_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [5:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       ram_enable, ram_read;
    logic [5:0] ram_address;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    int n_chk = 0;
    int n_pass = 0;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    ram64x8_arbiter #(.AW(6), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_enable(ram_enable), .ram_read(ram_read),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: data_out valid the cycle after a read enable.
    logic [7:0] ram_mem [64] = '{default: 8'h00};
    always @(posedge clk) begin
        if (reset) begin
            ram_data_out <= 8'h00;
        end else if (ram_enable) begin
            if (ram_read) ram_data_out <= ram_mem[ram_address];
            else          ram_mem[ram_address] <= ram_data_in;
        end
    end

    typedef struct {
        int         lat;
        int         en_cnt;
        logic       rd;
        logic [5:0] addr;
        logic [7:0] data;
        logic       other;
        logic [7:0] rdata;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [5:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    // Runs one transaction on port p from an IDLE cycle and reports what was seen.
    task automatic do_txn(input int p, input logic w, input logic [5:0] a,
                          input logic [7:0] d, output obs_t o);
        o = '{lat: 99, en_cnt: 0, rd: 1'b0, addr: 6'd0, data: 8'd0, other: 1'b0, rdata: 8'd0};
        set_port(p, 1'b1, w, a, d);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ram_enable) begin
                o.en_cnt++;
                o.rd   = ram_read;
                o.addr = ram_address;
                o.data = ram_data_in;
            end
            if ((p == 0) ? (gnt1 | ack1) : (gnt0 | ack0)) o.other = 1'b1;
            if ((p == 0) ? ack0 : ack1) begin
                o.lat   = i;
                o.rdata = (p == 0) ? rdata0 : rdata1;
                set_port(p, 1'b0, w, a, d);
                tick();
                break;
            end
        end
        set_port(p, 1'b0, w, a, d);
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_chk++;
        if ({gnt0, gnt1, ack0, ack1, ram_enable, ram_read} !== 6'b0)
            $display("FAIL reset_ctrl got=%b want=000000", {gnt0, gnt1, ack0, ack1, ram_enable, ram_read});
        else n_pass++;
        n_chk++;
        if ({rdata0, rdata1, ram_address, ram_data_in} !== 30'h0)
            $display("FAIL reset_data got=%h want=0", {rdata0, rdata1, ram_address, ram_data_in});
        else n_pass++;
    endtask

    task automatic test_single_write();
        obs_t o;
        apply_reset(2);
        do_txn(0, 1'b1, 6'd5, 8'hA5, o);
        n_chk++; if (o.lat !== 3) $display("FAIL wr_latency got=%0d want=3", o.lat); else n_pass++;
        n_chk++; if (o.en_cnt !== 1) $display("FAIL wr_enable_cycles got=%0d want=1", o.en_cnt); else n_pass++;
        n_chk++; if (o.rd !== 1'b0) $display("FAIL wr_ram_read got=%b want=0", o.rd); else n_pass++;
        n_chk++; if (o.addr !== 6'd5) $display("FAIL wr_address got=%0d want=5", o.addr); else n_pass++;
        n_chk++; if (o.data !== 8'hA5) $display("FAIL wr_data got=%h want=a5", o.data); else n_pass++;
        n_chk++; if (rdata0 !== 8'h00) $display("FAIL wr_rdata0 got=%h want=00", rdata0); else n_pass++;
    endtask

    task automatic test_read_back();
        obs_t o;
        do_txn(0, 1'b0, 6'd5, 8'h00, o);
        n_chk++; if (o.lat !== 3) $display("FAIL rd_latency got=%0d want=3", o.lat); else n_pass++;
        n_chk++; if (o.rd !== 1'b1) $display("FAIL rd_ram_read got=%b want=1", o.rd); else n_pass++;
        n_chk++; if (o.rdata !== 8'hA5) $display("FAIL rd_rdata0 got=%h want=a5", o.rdata); else n_pass++;
        n_chk++; if (o.other !== 1'b0) $display("FAIL rd_port1_quiet got=%b want=0", o.other); else n_pass++;
    endtask

    task automatic test_tie();
        obs_t o;
        int t0 = 99, t1 = 99;
        apply_reset(2);
        set_port(0, 1'b1, 1'b1, 6'd1, 8'h10);
        set_port(1, 1'b1, 1'b1, 6'd2, 8'h20);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ack0 && t0 == 99) begin t0 = i; req0 = 1'b0; end
            if (ack1 && t1 == 99) begin t1 = i; req1 = 1'b0; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_chk++; if (t0 !== 3) $display("FAIL tie_ack0_cycle got=%0d want=3", t0); else n_pass++;
        n_chk++; if (t1 !== 7) $display("FAIL tie_ack1_cycle got=%0d want=7", t1); else n_pass++;
        do_txn(0, 1'b0, 6'd1, 8'h00, o);
        n_chk++; if (o.rdata !== 8'h10) $display("FAIL tie_read_a1 got=%h want=10", o.rdata); else n_pass++;
        do_txn(1, 1'b0, 6'd2, 8'h00, o);
        n_chk++; if (o.rdata !== 8'h20) $display("FAIL tie_read_a2 got=%h want=20", o.rdata); else n_pass++;
    endtask

    task automatic test_top_address();
        obs_t o;
        do_txn(1, 1'b1, 6'd63, 8'h3F, o);
        n_chk++; if (o.addr !== 6'd63) $display("FAIL top_wr_address got=%0d want=63", o.addr); else n_pass++;
        do_txn(1, 1'b0, 6'd63, 8'h00, o);
        n_chk++; if (rdata1 !== 8'h3F) $display("FAIL top_rdata1 got=%h want=3f", rdata1); else n_pass++;
        do_txn(1, 1'b0, 6'd0, 8'h00, o);
        n_chk++; if (rdata1 !== 8'h00) $display("FAIL top_addr0_intact got=%h want=00", rdata1); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        obs_t o;
        int acks = 0;
        do_txn(0, 1'b1, 6'd9, 8'h5C, o);
        do_txn(0, 1'b0, 6'd9, 8'h00, o);
        n_chk++; if (rdata0 !== 8'h5C) $display("FAIL rst_pre_rdata0 got=%h want=5c", rdata0); else n_pass++;
        set_port(0, 1'b1, 1'b0, 6'd9, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        req0 = 1'b0;
        tick();
        n_chk++;
        if ({gnt0, ack0, ram_enable, rdata0} !== 11'h0)
            $display("FAIL rst_mid_read got gnt0=%b ack0=%b en=%b rdata0=%h want all 0",
                     gnt0, ack0, ram_enable, rdata0);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack0) acks++;
        end
        n_chk++; if (acks !== 0) $display("FAIL rst_no_ack got=%0d want=0", acks); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic e0, e1;
        int   j;
        apply_reset(2);
        set_port(0, 1'b1, 1'b0, 6'd1, 8'h00);
        set_port(1, 1'b1, 1'b0, 6'd2, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            tick();
            j  = (i - 3) / 4;
            e0 = (i % 4 == 3) && (!RR || (j % 2 == 0));
            e1 = (i % 4 == 3) && RR && (j % 2 == 1);
            n_chk++;
            if ({ack1, ack0} !== {e1, e0})
                $display("FAIL b2b_acks cycle=%0d got=%b%b want=%b%b", i, ack1, ack0, e1, e0);
            else n_pass++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    // Transaction-level reference: one accepted request per 4 cycles, ack 3 cycles after acceptance.
    task automatic test_random();
        bit         pend [2] = '{1'b0, 1'b0};
        logic       cwe [2];
        logic [5:0] caddr [2];
        logic [7:0] cdata [2];
        logic [7:0] ref_mem [64];
        logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
        int         acc = -100, idle_at = 0, ap = 0, last = 1, w;
        logic       awe = 1'b0, en;
        logic [5:0] aaddr = '0;
        logic [7:0] adata = '0, aval = '0;
        logic [3:0] exp_hs;
        apply_reset(2);
        for (int i = 0; i < 64; i++) ref_mem[i] = ram_mem[i];
        for (int k = 0; k < 400; k++) begin
            if (k == acc + 3 && !awe) exp_rd[ap] = aval;
            exp_hs = 4'b0;
            if (k > acc && k <= acc + 3) exp_hs[2 + ap] = 1'b1;
            if (k == acc + 3) exp_hs[ap] = 1'b1;
            en = (k == acc + 1);
            n_chk++;
            if ({gnt1, gnt0, ack1, ack0} !== exp_hs)
                $display("FAIL rnd_handshake k=%0d got=%b want=%b", k, {gnt1, gnt0, ack1, ack0}, exp_hs);
            else n_pass++;
            n_chk++;
            if ({ram_enable, ram_read, ram_address, ram_data_in} !== {en, en & ~awe, aaddr, adata})
                $display("FAIL rnd_ram_bus k=%0d got=%h want=%h", k,
                         {ram_enable, ram_read, ram_address, ram_data_in}, {en, en & ~awe, aaddr, adata});
            else n_pass++;
            n_chk++;
            if ({rdata1, rdata0} !== {exp_rd[1], exp_rd[0]})
                $display("FAIL rnd_rdata k=%0d got=%h want=%h", k, {rdata1, rdata0}, {exp_rd[1], exp_rd[0]});
            else n_pass++;

            if (k == acc + 3) pend[ap] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]  = 1'b1;
                    cwe[p]   = 1'($urandom_range(0, 1));
                    caddr[p] = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
                    cdata[p] = 8'($urandom);
                end
                set_port(p, pend[p], cwe[p], caddr[p], cdata[p]);
            end

            if (k >= idle_at && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = RR ? 1 - last : 0;
                else                    w = pend[0] ? 0 : 1;
                acc     = k;
                idle_at = k + 4;
                ap      = w;
                awe     = cwe[w];
                aaddr   = caddr[w];
                adata   = cdata[w];
                aval    = ref_mem[aaddr];
                if (awe) ref_mem[aaddr] = adata;
                last    = w;
            end
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_write();
        test_read_back();
        test_tie();
        test_top_address();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
